mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates between three requesters for a single-port synchronous memory: instruction fetch, data read (r0-indirect operand), and data write (r0-indirect result). It replaces the two-read/one-write memory model, so the pipelined core can run against a single-port SRAM. It sits between the core's fetch and execute stages and the memory macro. It registers one memory command per cycle and returns read data with fixed latency to the winning requester.

## Interface
- N, 8, address and data width
- STARVE_MAX, 4, consecutive fetch denials before fetch is forced to win (used only with MEMARB_STARVE_EN)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- if_req  in  1  fetch read request, level, held until granted
- if_addr  in  N  fetch address (PC)
- if_gnt  out  1  fetch grant, one-cycle pulse
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  N  fetch read data
- dr_req  in  1  data read request, level
- dr_addr  in  N  data read address (r0)
- dr_gnt  out  1  data read grant, one-cycle pulse
- dr_rvalid  out  1  data read data valid
- dr_rdata  out  N  data read data
- dw_req  in  1  data write request, level
- dw_addr  in  N  write address
- dw_data  in  N  write data
- dw_gnt  out  1  write grant, one-cycle pulse
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable, valid with mem_en
- mem_addr  out  N  memory address
- mem_wdata  out  N  memory write data
- mem_rdata  in  N  memory read data, valid the cycle after the read command

## Operation
- Eligible requester: req high and its gnt not currently high. This prevents a double grant of a request that has not yet been dropped.
- Fixed priority among eligible requesters: dw > dr > if. Writes win so a same-cycle read of the same address returns the new data.
- At each edge, exactly one eligible requester is selected, or none. The grant, mem_en, mem_we, mem_addr and mem_wdata are registered from that selection.
- Read path: a 2-bit registered tag {none, IF, DR} follows the command by one cycle. The tagged requester's rvalid is high for that cycle, and its rdata = mem_rdata. The untagged rdata holds its last value (registered capture).
- mem_addr and mem_wdata hold their last values while mem_en=0. mem_wdata is updated only on writes.
- Requester rule: sample gnt at the edge. The next cycle, either drop req or present a new request. A req still high after gnt is treated as a new request.

## Timing
- Reset values: all gnt, rvalid, mem_en and mem_we are 0. mem_addr, mem_wdata and both rdata are 0. The tag is none and the starvation counter is 0.
- Request sampled at edge k produces gnt and the memory command during cycle k+1, and rvalid plus data during cycle k+2. Read latency is 2 cycles from the sampled request.
- Throughput is one access per cycle across requesters. A single requester holding req continuously is granted at most every other cycle.
- With dw_req held continuously, the other requesters get slots only on alternate cycles.
- Reset mid-operation clears any in-flight tag, so no rvalid follows reset. A command issued in the reset cycle is not guaranteed to complete.

## Configuration
- MEMARB_STARVE_EN defined:
  - Adds a saturating counter of width clog2(STARVE_MAX+1).
  - It increments each cycle if_req is eligible and not selected. It clears when fetch is selected or if_req is low.
  - When the count equals STARVE_MAX, fetch has top priority for that selection.
- MEMARB_STARVE_EN undefined: no counter, pure fixed priority dw > dr > if.

## Test plan
- Reset with all reqs high, release at edge 0 -> dw_gnt in cycle 1 with mem_we=1. Then dr_gnt in cycle 2, dw_gnt in cycle 3, and so on. All outputs are 0 during reset.
- Single fetch, if_addr=0x10, mem returns 0xA5 -> if_gnt cycle 1, mem_addr=0x10 with mem_we=0, if_rvalid=1 and if_rdata=0xA5 in cycle 2.
- Same-cycle dw(addr 0x20, data 0x3C) and dr(addr 0x20) -> write issues first, read issues next cycle, dr_rdata=0x3C.
- dw and dr each held high 10 cycles alongside if_req:
  - MEMARB_STARVE_EN with STARVE_MAX=4: if_gnt is asserted within 5 cycles.
  - Undefined: if_gnt is never asserted while both are held.
- Assert reset in the cycle after dr_gnt -> dr_rvalid stays 0, and all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for fetch, data-read and data-write requesters (priority dw > dr > if).
// Define MEMARB_STARVE_EN to add a fetch anti-starvation counter that forces fetch after STARVE_MAX denials.
module mem_port_arbiter #(
    parameter int N          = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         if_req,
    input  logic [N-1:0] if_addr,
    output logic         if_gnt,
    output logic         if_rvalid,
    output logic [N-1:0] if_rdata,
    input  logic         dr_req,
    input  logic [N-1:0] dr_addr,
    output logic         dr_gnt,
    output logic         dr_rvalid,
    output logic [N-1:0] dr_rdata,
    input  logic         dw_req,
    input  logic [N-1:0] dw_addr,
    input  logic [N-1:0] dw_data,
    output logic         dw_gnt,
    output logic         mem_en,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_IF   = 2'd1,
        TAG_DR   = 2'd2
    } tag_t;

    logic         if_gnt_reg, dr_gnt_reg, dw_gnt_reg;
    logic         mem_en_reg, mem_we_reg;
    logic [N-1:0] mem_addr_reg, mem_wdata_reg;
    tag_t         tag_reg;

    logic         if_elig, dr_elig, dw_elig;
    logic         sel_if, sel_dr, sel_dw;

    // A requester whose grant is showing this cycle has not yet had a chance to drop req.
    assign if_elig = if_req & ~if_gnt_reg;
    assign dr_elig = dr_req & ~dr_gnt_reg;
    assign dw_elig = dw_req & ~dw_gnt_reg;

`ifdef MEMARB_STARVE_EN
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt_reg, starve_cnt_next;
    logic          starve_force;

    assign starve_force = (starve_cnt_reg == STARVE_LIM);

    always_comb begin
        sel_if = 1'b0;
        sel_dr = 1'b0;
        sel_dw = 1'b0;
        if (if_elig && starve_force) begin
            sel_if = 1'b1;
        end else if (dw_elig) begin
            sel_dw = 1'b1;
        end else if (dr_elig) begin
            sel_dr = 1'b1;
        end else if (if_elig) begin
            sel_if = 1'b1;
        end
    end

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!if_req || sel_if) begin
            starve_cnt_next = '0;
        end else if (if_elig && !starve_force) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end
`else
    always_comb begin
        sel_if = 1'b0;
        sel_dr = 1'b0;
        sel_dw = 1'b0;
        if (dw_elig) begin
            sel_dw = 1'b1;
        end else if (dr_elig) begin
            sel_dr = 1'b1;
        end else if (if_elig) begin
            sel_if = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_gnt_reg    <= 1'b0;
            dr_gnt_reg    <= 1'b0;
            dw_gnt_reg    <= 1'b0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            tag_reg       <= TAG_NONE;
        end else begin
            if_gnt_reg <= sel_if;
            dr_gnt_reg <= sel_dr;
            dw_gnt_reg <= sel_dw;
            mem_en_reg <= sel_if | sel_dr | sel_dw;
            mem_we_reg <= sel_dw;
            if (sel_dw) begin
                mem_addr_reg  <= dw_addr;
                mem_wdata_reg <= dw_data;
            end else if (sel_dr) begin
                mem_addr_reg <= dr_addr;
            end else if (sel_if) begin
                mem_addr_reg <= if_addr;
            end
            // The tag trails the issued read command so it lines up with mem_rdata.
            tag_reg <= if_gnt_reg ? TAG_IF : (dr_gnt_reg ? TAG_DR : TAG_NONE);
        end
    end

    logic [1:0]   rvalid_vec;
    logic [N-1:0] rdata_vec [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rport
            localparam tag_t PORT_TAG = (gi == 0) ? TAG_IF : TAG_DR;
            logic [N-1:0] rdata_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rdata_reg <= '0;
                end else if (tag_reg == PORT_TAG) begin
                    rdata_reg <= mem_rdata;
                end
            end

            assign rvalid_vec[gi] = (tag_reg == PORT_TAG);
            assign rdata_vec[gi]  = rvalid_vec[gi] ? mem_rdata : rdata_reg;
        end
    endgenerate

    assign if_gnt    = if_gnt_reg;
    assign dr_gnt    = dr_gnt_reg;
    assign dw_gnt    = dw_gnt_reg;
    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign if_rvalid = rvalid_vec[0];
    assign if_rdata  = rdata_vec[0];
    assign dr_rvalid = rvalid_vec[1];
    assign dr_rdata  = rdata_vec[1];

endmodule
